multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main control unit for a classic multicycle MIPS-style datapath. A Moore FSM
// sequences each instruction through fetch, decode and the class-specific
// execute/memory/write-back states. The only Mealy-style outputs are IRWrite
// and PCWrite in IF, which follow MemReady so the fetch commits only when
// memory has delivered the instruction.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active low
//   OpCode[5:0]  in   opcode field of the instruction register
//   Funct[5:0]   in   funct field of the instruction register
//   MemReady     in   memory completed the current access this cycle
//   PCWrite      out  unconditional PC load
//   PCWriteCond  out  PC load qualified by ALU Zero
//   IorD         out  memory address select (0=PC, 1=ALUOut)
//   MemRead      out  memory read request
//   MemWrite     out  memory write request
//   IRWrite      out  instruction register load
//   RegDst       out  register destination (0=rt, 1=rd)
//   RegWrite     out  register file write
//   MemtoReg     out  write-back source (0=ALUOut, 1=MDR)
//   ALUSrcA      out  ALU A operand (0=PC, 1=A)
//   ALUSrcB[1:0] out  ALU B operand (00=B, 01=4, 10=imm, 11=imm<<2)
//   ALUOp[1:0]   out  00=add, 01=sub, 10=by Funct, 11=by OpCode
//   PCSource[1:0]out  00=ALU, 01=ALUOut, 10=jump target, 11=A
//   State[3:0]   out  current state code
//   InstCount    out  number of retired instructions (wraps)
//
// While reset is low every control output is forced to 0 combinationally, so
// a pending memory request or register write is dropped immediately rather
// than at the next clock.
// -----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Funct,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  State,
    output logic [31:0] InstCount
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REX  = 4'd6,
        S_RWB  = 4'd7,
        S_BEQ  = 4'd8,
        S_JMP  = 4'd9,
        S_IEX  = 4'd10,
        S_IWB  = 4'd11,
        S_JR   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        retire_s;

    // Decoded control values before the reset gate.
    logic        pc_write_s;
    logic        pc_write_cond_s;
    logic        iord_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        ir_write_s;
    logic        reg_dst_s;
    logic        reg_write_s;
    logic        mem_to_reg_s;
    logic        alu_src_a_s;
    logic [1:0]  alu_src_b_s;
    logic [1:0]  alu_op_s;
    logic [1:0]  pc_source_s;

    // State and retired-instruction counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IF;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic and retire detection.
    always_comb begin
        state_d  = S_IF;
        retire_s = 1'b0;
        case (state_q)
            S_IF: begin
                if (MemReady) begin
                    state_d = S_ID;
                end else begin
                    state_d = S_IF;
                end
            end
            S_ID: begin
                case (OpCode)
                    OP_LW, OP_SW: state_d = S_MADR;
                    OP_RTYPE: begin
                        if (Funct == FN_JR) begin
                            state_d = S_JR;
                        end else begin
                            state_d = S_REX;
                        end
                    end
                    OP_BEQ:                          state_d = S_BEQ;
                    OP_J:                            state_d = S_JMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEX;
                    // Unsupported opcode: drop it without retiring.
                    default:                         state_d = S_IF;
                endcase
            end
            S_MADR: begin
                if (OpCode == OP_SW) begin
                    state_d = S_MWR;
                end else begin
                    state_d = S_MRD;
                end
            end
            S_MRD: begin
                if (MemReady) begin
                    state_d = S_MWB;
                end else begin
                    state_d = S_MRD;
                end
            end
            S_MWR: begin
                if (MemReady) begin
                    state_d  = S_IF;
                    retire_s = 1'b1;
                end else begin
                    state_d  = S_MWR;
                end
            end
            S_REX: state_d = S_RWB;
            S_IEX: state_d = S_IWB;
            S_MWB, S_RWB, S_IWB, S_BEQ, S_JMP, S_JR: begin
                state_d  = S_IF;
                retire_s = 1'b1;
            end
            // Unused codes 13-15 recover to fetch.
            default: state_d = S_IF;
        endcase
    end

    // Retired-instruction counter; wraps naturally at 32 bits.
    always_comb begin
        if (retire_s) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Per-state control decode; anything not set is 0 in that state.
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        mem_to_reg_s    = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        pc_source_s     = 2'b00;
        case (state_q)
            S_IF: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                // Fetch commits IR and PC+4 only on the cycle memory answers.
                ir_write_s  = MemReady;
                pc_write_s  = MemReady;
            end
            S_ID: begin
                alu_src_b_s = 2'b11;
            end
            S_MADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MRD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MWR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            S_REX: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            S_RWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            S_IEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                alu_op_s    = 2'b11;
            end
            S_IWB: begin
                reg_write_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_source_s     = 2'b01;
            end
            S_JMP: begin
                pc_write_s  = 1'b1;
                pc_source_s = 2'b10;
            end
            S_JR: begin
                pc_write_s  = 1'b1;
                pc_source_s = 2'b11;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Output stage: reset low silences every control line without a clock.
    always_comb begin
        if (!reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            MemtoReg    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
        end else begin
            PCWrite     = pc_write_s;
            PCWriteCond = pc_write_cond_s;
            IorD        = iord_s;
            MemRead     = mem_read_s;
            MemWrite    = mem_write_s;
            IRWrite     = ir_write_s;
            RegDst      = reg_dst_s;
            RegWrite    = reg_write_s;
            MemtoReg    = mem_to_reg_s;
            ALUSrcA     = alu_src_a_s;
            ALUSrcB     = alu_src_b_s;
            ALUOp       = alu_op_s;
            PCSource    = pc_source_s;
        end
    end

    assign State     = state_q;
    assign InstCount = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Self-checking bench for multicycle_ctrl. Each instruction is turned into an
// expected per-cycle plan (state code and the MemReady value to drive) from
// the instruction class and chosen stall counts. Every cycle the bench checks
// State, the packed control vector against a per-state table, and InstCount
// against a running retire count.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic        MemReady;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegDst;
    logic        RegWrite;
    logic        MemtoReg;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic [1:0]  PCSource;
    logic [3:0]  State;
    logic [31:0] InstCount;

    int n_checks;
    int n_fail;

    logic [31:0] exp_count;
    int          plan_st[$];
    bit          plan_mr[$];
    int          mwr_cycles;

    logic [15:0] ctrl_obs;
    assign ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       RegDst, RegWrite, MemtoReg, ALUSrcA,
                       ALUSrcB, ALUOp, PCSource};

    multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .State       (State),
        .InstCount   (InstCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected control outputs for a state, written field by field from the
    // control table; MemReady only matters in IF.
    function automatic logic [15:0] exp_ctrl(input int st, input bit mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, rdst, rw, m2r, asa;
        logic [1:0] asb, aop, pcs;
        pcw = 1'b0; pcwc = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0;
        irw = 1'b0; rdst = 1'b0; rw = 1'b0; m2r = 1'b0; asa = 1'b0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  begin asb = 2'b11; end
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mwr = 1'b1; iord = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rw = 1'b1; rdst = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            9:  begin pcw = 1'b1; pcs = 2'b10; end
            10: begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
            11: begin rw = 1'b1; end
            12: begin pcw = 1'b1; pcs = 2'b11; end
            default: begin pcw = 1'b0; end
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, rdst, rw, m2r, asa, asb, aop, pcs};
    endfunction

    function automatic bit rnd_bit();
        return 1'($urandom_range(1, 0));
    endfunction

    // Builds the cycle plan for one instruction, drives it and checks it.
    // Entered with the DUT in IF; returns with the final cycle's posedge
    // still to come (that edge performs the return to IF).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int s_if, input int s_mem);
        bit retire;
        plan_st.delete();
        plan_mr.delete();
        retire = 1'b1;
        for (int k = 0; k < s_if; k++) begin plan_st.push_back(0); plan_mr.push_back(1'b0); end
        plan_st.push_back(0); plan_mr.push_back(1'b1);
        plan_st.push_back(1); plan_mr.push_back(rnd_bit());
        if (op == 6'h23) begin
            plan_st.push_back(2); plan_mr.push_back(rnd_bit());
            for (int k = 0; k < s_mem; k++) begin plan_st.push_back(3); plan_mr.push_back(1'b0); end
            plan_st.push_back(3); plan_mr.push_back(1'b1);
            plan_st.push_back(4); plan_mr.push_back(rnd_bit());
        end else if (op == 6'h2B) begin
            plan_st.push_back(2); plan_mr.push_back(rnd_bit());
            for (int k = 0; k < s_mem; k++) begin plan_st.push_back(5); plan_mr.push_back(1'b0); end
            plan_st.push_back(5); plan_mr.push_back(1'b1);
        end else if (op == 6'h00) begin
            if (fn == 6'h08) begin
                plan_st.push_back(12); plan_mr.push_back(rnd_bit());
            end else begin
                plan_st.push_back(6); plan_mr.push_back(rnd_bit());
                plan_st.push_back(7); plan_mr.push_back(rnd_bit());
            end
        end else if (op == 6'h04) begin
            plan_st.push_back(8); plan_mr.push_back(rnd_bit());
        end else if (op == 6'h02) begin
            plan_st.push_back(9); plan_mr.push_back(rnd_bit());
        end else if (op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D) begin
            plan_st.push_back(10); plan_mr.push_back(rnd_bit());
            plan_st.push_back(11); plan_mr.push_back(rnd_bit());
        end else begin
            retire = 1'b0;
        end
        mwr_cycles = 0;
        for (int i = 0; i < plan_st.size(); i++) begin
            @(negedge clk);
            OpCode   = op;
            Funct    = fn;
            MemReady = plan_mr[i];
            #1;
            check_eq("state", 32'(State), 32'(plan_st[i]));
            check_eq("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(plan_st[i], plan_mr[i])));
            check_eq("count", InstCount, exp_count);
            if (MemWrite) mwr_cycles = mwr_cycles + 1;
        end
        if (retire) exp_count = exp_count + 32'd1;
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [10];
        logic [5:0] r;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h02, 6'h08, 6'h0A, 6'h0C, 6'h0D};
        if ($urandom_range(9, 0) == 0) begin
            r = 6'($urandom_range(63, 0));
            if (r inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B}) r = 6'h3F;
            return r;
        end
        return ops[$urandom_range(9, 0)];
    endfunction

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        n_checks  = 0;
        n_fail    = 0;
        exp_count = 32'd0;
        reset     = 1'b0;
        MemReady  = 1'b1;
        OpCode    = 6'h00;
        Funct     = 6'h00;

        // Reset state, both before and after clock edges.
        #3;
        check_eq("rst_state", 32'(State), 32'd0);
        check_eq("rst_ctrl", 32'(ctrl_obs), 32'd0);
        check_eq("rst_count", InstCount, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_ctrl", 32'(ctrl_obs), 32'd0);
        @(negedge clk);
        MemReady = 1'b0;
        reset    = 1'b1;

        // lw with no stalls: 0,1,2,3,4.
        run_instr(6'h23, 6'h00, 0, 0);
        // sw with three MWR wait cycles.
        run_instr(6'h2B, 6'h00, 0, 3);
        check_eq("sw_memwrite_cycles", 32'(mwr_cycles), 32'd4);
        // R-type add, then jr.
        run_instr(6'h00, 6'h20, 0, 0);
        run_instr(6'h00, 6'h08, 0, 0);
        // Unsupported opcode.
        run_instr(6'h3F, 6'h00, 0, 0);
        // Fetch stalls, beq, I-type.
        run_instr(6'h04, 6'h00, 2, 0);
        run_instr(6'h0D, 6'h00, 1, 0);
        run_instr(6'h23, 6'h00, 1, 2);

        // Reset pulled low mid-lw while waiting in MRD.
        @(negedge clk); OpCode = 6'h23; MemReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); MemReady = 1'b0;
        #1;
        check_eq("pre_rst_state", 32'(State), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_state", 32'(State), 32'd0);
        check_eq("mid_rst_ctrl", 32'(ctrl_obs), 32'd0);
        check_eq("mid_rst_count", InstCount, 32'd0);
        @(posedge clk);
        #1;
        check_eq("mid_rst_hold", 32'(ctrl_obs), 32'd0);
        @(negedge clk);
        MemReady  = 1'b0;
        reset     = 1'b1;
        exp_count = 32'd0;
        run_instr(6'h08, 6'h00, 0, 0);

        // Counter wrap: preload all-ones, then retire a jump.
        @(negedge clk);
        MemReady = 1'b0;
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        #1;
        check_eq("preload_count", InstCount, 32'hFFFF_FFFF);
        exp_count = 32'hFFFF_FFFF;
        run_instr(6'h02, 6'h00, 0, 0);
        @(negedge clk);
        MemReady = 1'b0;
        #1;
        check_eq("wrap_count", InstCount, 32'd0);
        exp_count = 32'd0;

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            op = pick_op();
            fn = ($urandom_range(3, 0) == 0) ? 6'h08 : 6'($urandom_range(63, 0));
            run_instr(op, fn, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        end
        @(negedge clk);
        MemReady = 1'b0;
        #1;
        check_eq("final_count", InstCount, exp_count);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
